cpu_csr_seq: RTL

Sequencer for Zicsr instructions, placed between the execute stage and the CSR file. It accepts one CSRRW/CSRRS/CSRRC (register or immediate form) per request and issues a CSR read, then a read-modify-write computation, then a CSR write. It returns the old CSR value for rd. Fixed latency, one operation in flight, driving the CSR file's registered read port and its write port.

---
 rtl/common_pkg.sv | 19 +
 rtl/cpu_csr_alu.sv | 20 ++
 rtl/cpu_csr_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared CPU types: CSR address/word/cause types, Zicsr funct3 encodings and exception codes.
package common;

  typedef logic [11:0] csr_t;
  typedef logic [31:0] word_t;
  typedef logic [31:0] mcause_t;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_t;

  localparam logic [30:0] EXC_ILLEGAL_INSTR = 31'd2;

endpackage

// File: rtl/cpu_csr_alu.sv
// Zicsr read-modify-write datapath: new CSR value from op, old value and source operand.
module cpu_csr_alu
  import common::*;
(
  input  csr_op_t op_i,
  input  word_t   old_i,
  input  word_t   src_i,
  output word_t   new_o
);

  always_comb begin
    new_o = old_i | src_i;
    case (op_i)
      CSR_OP_RW, CSR_OP_RWI: new_o = src_i;
      CSR_OP_RC, CSR_OP_RCI: new_o = old_i & ~src_i;
      default:               new_o = old_i | src_i;
    endcase
  end

endmodule

// File: rtl/cpu_csr_seq.sv
// Zicsr sequencer: read, modify, write, respond with the old CSR value.
// Optional CSR_SEQ_ILLEGAL_EN traps writes to read-only CSRs (addr[11:10] == 2'b11).
module cpu_csr_seq
  import common::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_rs1_i,
  input  logic [4:0]  req_uimm_i,
  input  logic        req_rd_zero_i,
  input  logic        req_rs1_zero_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic [11:0] csr_read_addr_o,
  output logic        csr_read_enable_o,
  input  logic [31:0] csr_read_data_i,
  output logic [11:0] csr_write_addr_o,
  output logic [31:0] csr_write_data_o,
  output logic        csr_write_enable_o
`ifdef CSR_SEQ_ILLEGAL_EN
  ,
  output logic        trap_o,
  output logic [31:0] trap_cause_o
`endif
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRead   = 2'd1;
  localparam logic [1:0] StModify = 2'd2;
  localparam logic [1:0] StWrite  = 2'd3;

  logic [1:0]  state_q, state_d;
  csr_op_t     op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] src_q, src_d;
  logic [31:0] old_q, old_d;
  logic        rd_zero_q, rd_zero_d;
  logic        rs1_zero_q, rs1_zero_d;

  logic        is_write_op;
  logic        read_issued;
  logic        write_req;
  logic        in_write;
  logic        wr_blocked;
  logic [31:0] new_val;

  assign is_write_op = (op_q == CSR_OP_RW) || (op_q == CSR_OP_RWI);
  // CSRRW with rd=x0 must not produce read side effects.
  assign read_issued = !(is_write_op && rd_zero_q);
  assign write_req   = is_write_op || !rs1_zero_q;
  assign in_write    = (state_q == StWrite) && !flush_i;

`ifdef CSR_SEQ_ILLEGAL_EN
  assign wr_blocked   = write_req && (addr_q[11:10] == 2'b11);
  assign trap_o       = in_write && wr_blocked;
  assign trap_cause_o = trap_o ? {1'b0, EXC_ILLEGAL_INSTR} : '0;
`else
  assign wr_blocked   = 1'b0;
`endif

  cpu_csr_alu u_alu (
    .op_i  (op_q),
    .old_i (old_q),
    .src_i (src_q),
    .new_o (new_val)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    src_d      = src_q;
    old_d      = old_q;
    rd_zero_d  = rd_zero_q;
    rs1_zero_d = rs1_zero_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i && !flush_i) begin
          addr_d    = req_addr_i;
          src_d     = req_op_i[2] ? {27'b0, req_uimm_i} : req_rs1_i;
          rd_zero_d = req_rd_zero_i;
          // Reserved funct3 (000/100) degrade to a read-only CSRRS.
          if (req_op_i[1:0] == 2'b00) begin
            op_d       = CSR_OP_RS;
            rs1_zero_d = 1'b1;
          end else begin
            op_d       = csr_op_t'(req_op_i);
            rs1_zero_d = req_rs1_zero_i;
          end
          state_d = StRead;
        end
      end
      StRead:   state_d = StModify;
      StModify: begin
        old_d   = read_issued ? csr_read_data_i : '0;
        state_d = StWrite;
      end
      default:  state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      op_q       <= CSR_OP_RW;
      addr_q     <= '0;
      src_q      <= '0;
      old_q      <= '0;
      rd_zero_q  <= 1'b0;
      rs1_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      old_q      <= old_d;
      rd_zero_q  <= rd_zero_d;
      rs1_zero_q <= rs1_zero_d;
    end
  end

  assign req_ready_o        = (state_q == StIdle) && !flush_i;
  assign csr_read_enable_o  = (state_q == StRead) && read_issued;
  assign csr_read_addr_o    = (state_q == StRead) ? addr_q : '0;
  assign csr_write_enable_o = in_write && write_req && !wr_blocked;
  assign csr_write_addr_o   = (state_q == StWrite) ? addr_q : '0;
  assign csr_write_data_o   = (state_q == StWrite) ? new_val : '0;
  assign rsp_valid_o        = in_write && !wr_blocked;
  assign rsp_data_o         = (state_q == StWrite) ? old_q : '0;

endmodule
